// File: rtl/regfile_write_ctrl_pkg.sv
// Shared types and constants for the MIPS16 register-file write-port controller.
package mips_16_rf_pkg;

    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned REG_DATA_W = 16;
    localparam int unsigned NUM_REGS   = 8;
    localparam logic [REG_ADDR_W-1:0] LAST_REG = 3'd7;

    typedef enum logic {
        ARB  = 1'b0,
        INIT = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Requester-side write bus: valid/ready handshake with packed per-requester dest and data.
interface regfile_write_ctrl_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_dest;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_dest, output req_data, input req_ready);
    modport slave  (input req_valid, input req_dest, input req_data, output req_ready);
endinterface

// File: rtl/regfile_write_ctrl_rr_arbiter.sv
// Round-robin arbiter: first active request at or after ptr_i (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [PTR_W-1:0]   gnt_idx_c_o
);

    int unsigned      cand;
    logic [PTR_W-1:0] cidx;
    logic             found;

    always_comb begin
        gnt_c_o     = '0;
        gnt_idx_c_o = '0;
        found       = 1'b0;
        cand        = 0;
        cidx        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr_i) + i) % NUM_REQ;
            cidx = PTR_W'(cand);
            if (en_i && !found && req_i[cidx]) begin
                found          = 1'b1;
                gnt_c_o[cidx]  = 1'b1;
                gnt_idx_c_o    = cidx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Write-port controller: round-robin requester arbitration plus an r1..r7 fill sequence.
import mips_16_rf_pkg::*;

module regfile_write_ctrl #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = REG_DATA_W,
    parameter int unsigned ADDR_W  = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_write_ctrl_if.slave  req_if,
    input  logic                 init_start_i,
    input  logic [DATA_W-1:0]    init_value_i,
    output logic                 init_busy_o,
    output logic                 init_done_o,
    output logic                 reg_write_en_o,
    output logic [ADDR_W-1:0]    reg_write_dest_o,
    output logic [DATA_W-1:0]    reg_write_data_o
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   wdest_q, wdest_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;

    logic                arb_en_c;
    logic [NUM_REQ-1:0]  gnt_c;
    logic [PTR_W-1:0]    gnt_idx_c;
    logic [ADDR_W-1:0]   sel_dest_c;
    logic [DATA_W-1:0]   sel_data_c;

    // init_start wins over any simultaneous request; nothing is granted during reset
    assign arb_en_c = rst_n && (state_q == ARB) && !init_start_i;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req_i       (req_if.req_valid),
        .ptr_i       (rr_ptr_q),
        .en_i        (arb_en_c),
        .gnt_c_o     (gnt_c),
        .gnt_idx_c_o (gnt_idx_c)
    );

    assign req_if.req_ready = gnt_c;

    always_comb begin
        sel_dest_c = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_dest_c = req_if.req_dest[i*ADDR_W +: ADDR_W];
                sel_data_c = req_if.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        fill_d   = fill_q;
        wen_d    = 1'b0;
        wdest_d  = '0;
        wdata_d  = '0;
        done_d   = 1'b0;
        case (state_q)
            ARB: begin
                if (init_start_i) begin
                    state_d = INIT;
                    idx_d   = ADDR_W'(1);
                    fill_d  = init_value_i;
                end else if (|gnt_c) begin
                    rr_ptr_d = (gnt_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
                    // writes to r0 are accepted but dropped
                    if (sel_dest_c != '0) begin
                        wen_d   = 1'b1;
                        wdest_d = sel_dest_c;
                        wdata_d = sel_data_c;
                    end
                end
            end
            INIT: begin
                wen_d   = 1'b1;
                wdest_d = idx_q;
                wdata_d = fill_q;
                if (idx_q == ADDR_W'(LAST_REG)) begin
                    state_d = ARB;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            fill_q   <= '0;
            wen_q    <= 1'b0;
            wdest_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            fill_q   <= fill_d;
            wen_q    <= wen_d;
            wdest_q  <= wdest_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
        end
    end

    assign init_busy_o      = (state_q == INIT);
    assign init_done_o      = done_q;
    assign reg_write_en_o   = wen_q;
    assign reg_write_dest_o = wdest_q;
    assign reg_write_data_o = wdata_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl; expected writes flow through a one-cycle scoreboard queue.
module tb_regfile_write_ctrl;

    typedef struct packed {
        logic        en;
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_start;
    logic [15:0] init_value;
    logic        init_busy, init_done;
    logic        wen;
    logic [2:0]  wdest;
    logic [15:0] wdata;

    int total = 0;
    int bad   = 0;
    wr_t sb[$];

    always #5 clk = ~clk;

    regfile_write_ctrl_if #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(3)) rif ();

    regfile_write_ctrl #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_if           (rif.slave),
        .init_start_i     (init_start),
        .init_value_i     (init_value),
        .init_busy_o      (init_busy),
        .init_done_o      (init_done),
        .reg_write_en_o   (wen),
        .reg_write_dest_o (wdest),
        .reg_write_data_o (wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check ready now, queue the write due next cycle, then check registered outputs.
    task automatic tick(input logic [2:0] exp_ready, input logic exp_en, input logic [2:0] exp_dest,
                        input logic [15:0] exp_data, input logic exp_busy, input logic exp_done);
        wr_t e, o;
        #1;
        chk("req_ready", 32'(rif.req_ready), 32'(exp_ready));
        e = '{en: exp_en, dest: exp_dest, data: exp_data};
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk("reg_write_en", 32'(wen), 32'(o.en));
        if (o.en) begin
            chk("reg_write_dest", 32'(wdest), 32'(o.dest));
            chk("reg_write_data", 32'(wdata), 32'(o.data));
        end
        chk("init_busy", 32'(init_busy), 32'(exp_busy));
        chk("init_done", 32'(init_done), 32'(exp_done));
        @(negedge clk);
    endtask

    // Fill sequence from cycle T through T+7; repulse re-asserts init_start at that offset.
    task automatic run_init(input logic [15:0] v, input int repulse);
        init_start = 1'b1;
        init_value = v;
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            init_start = (k == repulse);
            init_value = ~v;
            tick(3'b000, 1'b1, 3'(k), v, k < 7, k == 7);
        end
        init_start = 1'b0;
    endtask

    task automatic set_reqs_123();
        rif.req_dest = {3'd3, 3'd2, 3'd1};
        rif.req_data = {16'h3333, 16'h2222, 16'h1111};
    endtask

    initial begin
        rst_n         = 1'b0;
        init_start    = 1'b0;
        init_value    = 16'h0;
        rif.req_valid = 3'b000;
        rif.req_dest  = '0;
        rif.req_data  = '0;
        @(negedge clk);

        // reset, then idle
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        chk("rst_dest", 32'(wdest), 32'd0);
        chk("rst_data", 32'(wdata), 32'd0);
        rst_n = 1'b1;
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

        // single request from requester 1
        rif.req_valid = 3'b010;
        rif.req_dest  = {3'd0, 3'd3, 3'd0};
        rif.req_data  = {16'h0, 16'hABCD, 16'h0};
        tick(3'b010, 1'b1, 3'd3, 16'hABCD, 1'b0, 1'b0);
        rif.req_valid = 3'b000;
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

        // fresh pointer, all three requesting back to back
        rst_n = 1'b0;
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        set_reqs_123();
        rif.req_valid = 3'b111;
        for (int r = 0; r < 6; r++) begin
            case (r % 3)
                0:       tick(3'b001, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b0);
                1:       tick(3'b010, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0);
                default: tick(3'b100, 1'b1, 3'd3, 16'h3333, 1'b0, 1'b0);
            endcase
        end

        // pointer -> 1, then a dropped write to r0 from requester 2, then requester 0 next
        rif.req_valid = 3'b001;
        tick(3'b001, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b0);
        rif.req_valid = 3'b100;
        rif.req_dest  = {3'd0, 3'd2, 3'd1};
        rif.req_data  = {16'h1234, 16'h2222, 16'h1111};
        tick(3'b100, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        set_reqs_123();
        rif.req_valid = 3'b101;
        tick(3'b001, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b0);

        // init sequence beats a held request; request granted at T+8
        rif.req_valid = 3'b001;
        rif.req_dest  = {3'd3, 3'd2, 3'd5};
        rif.req_data  = {16'h3333, 16'h2222, 16'h0777};
        run_init(16'h5A5A, 0);
        tick(3'b001, 1'b1, 3'd5, 16'h0777, 1'b0, 1'b0);
        rif.req_valid = 3'b000;
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

        // reset asserted in T+4 of a fill aborts it
        init_start = 1'b1;
        init_value = 16'h0F0F;
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        init_start = 1'b0;
        for (int k = 1; k <= 3; k++)
            tick(3'b000, 1'b1, 3'(k), 16'h0F0F, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        set_reqs_123();
        rif.req_valid = 3'b111;
        tick(3'b001, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b0);
        rif.req_valid = 3'b000;

        // re-pulsed init_start during INIT is ignored
        run_init(16'hC3C3, 3);
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        tick(3'b000, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 8-entry, 16-bit MIPS16 register file. Shares the file's single synchronous write port between NUM_REQ requesters (writeback stage, multi-cycle unit, debug port) by round-robin arbitration over a valid/ready handshake. Also runs an init sequence that fills r1..r7 with a programmable value. Sits directly in front of the register file write port; read ports are untouched.

## Interface
- NUM_REQ, 3, number of write requesters (2..4)
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (8 registers)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester write request
- req_dest  in  NUM_REQ*ADDR_W  destination register, requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  write data, requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot or zero, accept this cycle (combinational)
- init_start  in  1  pulse, start fill sequence
- init_value  in  DATA_W  fill value, sampled with init_start
- init_busy  out  1  fill sequence in progress
- init_done  out  1  one-cycle pulse, aligned with the last fill write
- reg_write_en  out  1  to register file
- reg_write_dest  out  ADDR_W  to register file
- reg_write_data  out  DATA_W  to register file

## Operation
- FSM states: ARB, INIT. Reset state ARB.
- ARB:
  - Grant at most one valid requester per cycle, round-robin.
  - Search starts at rr_ptr and wraps; rr_ptr moves to granted+1 (mod NUM_REQ) on each grant.
  - req_ready[i]=1 only for the granted i and may depend on req_valid.
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold valid/dest/data stable until accepted.
- Transfer to dest 0: accepted (ready high, rr_ptr advances) but reg_write_en stays 0; the write is dropped.
- init_start in ARB:
  - Latch init_value; go to INIT with idx=1.
  - No grant that cycle; init beats simultaneous requests.
- INIT:
  - All req_ready=0.
  - Each cycle issue write idx<-fill value, idx increments 1..7; r0 is never written.
  - After idx 7 is issued, return to ARB.
  - init_start while in INIT is ignored.
- rr_ptr is not modified by INIT.

## Timing
- Reset (rst_n low at an edge):
  - Next cycle: state ARB, rr_ptr 0, idx 0.
  - reg_write_en/dest/data 0, init_busy 0, init_done 0, req_ready 0 while rst_n low.
- Reset mid-INIT aborts the sequence: no init_done, no further fill writes.
- reg_write_* are registered. A transfer accepted in cycle T appears on reg_write_* in cycle T+1 only.
  - reg_write_en is 0 in any cycle not preceded by an accepted write.
- Throughput: one write per cycle; back-to-back grants allowed.
- init_start sampled high in cycle T:
  - init_busy high cycles T+1..T+7.
  - Fill writes r1..r7 on reg_write_* in cycles T+2..T+8.
  - init_done pulses in cycle T+8.
  - Grants resume in T+8; the first such write appears in T+9.

## Structure
- Package mips_16_rf_pkg:
  - state enum {ARB, INIT}
  - REG_ADDR_W=3, REG_DATA_W=16, NUM_REGS=8, LAST_REG=3'd7
- Sub-module rr_arbiter:
  - Parameterized NUM_REQ.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
- Top holds the FSM, rr_ptr, idx, init value latch and output registers.

## Test plan
- Reset then idle: all outputs 0. Single req_valid[1], dest 3, data 16'hABCD -> req_ready[1] same cycle; next cycle reg_write_en=1, dest 3, data 16'hABCD.
- All three valid continuously, dests 1/2/3 -> grants 0,1,2,0,1,2 on consecutive cycles; writes back-to-back with 1-cycle lag.
- Requester 2 writes dest 0, data 16'h1234 -> req_ready[2] asserted, reg_write_en stays 0, next grant goes to requester 0.
- init_start with init_value 16'h5A5A at T, plus req_valid[0] held -> no ready until T+8; writes r1..r7=16'h5A5A in T+2..T+8; init_done only at T+8; requester 0 granted at T+8, its write in T+9.
- rst_n low at T+4 of an init sequence -> outputs 0 from T+5, no init_done, state ARB after release, rr_ptr 0.
- init_start re-pulsed during INIT -> ignored; exactly 7 fill writes, one init_done.
